// File: rtl/branch_pred_pkg.sv
// Shared types and helpers for the branch predictor controller and its pattern history table.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package branch_pred_pkg;

   // 2-bit saturating counter encodings; bit 1 is the taken prediction
   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } cnt_t;

   // Controller states: sweeping the table, or serving predictions/updates
   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } ctrl_state_t;

   localparam logic [1:0] CNT_MAX = ST;
   localparam logic [1:0] CNT_MIN = SNT;

   // Saturating step of a 2-bit counter toward the resolved outcome
   function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
      logic [1:0] nxt;
      nxt = cnt;
      if (taken) begin
         if (cnt != CNT_MAX) nxt = cnt + 2'd1;
      end else begin
         if (cnt != CNT_MIN) nxt = cnt - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/branch_pred_ctrl_pht_ram.sv
// Pattern history table: async fetch read, sync write muxed between sweep init and branch RMW.
// Latency: read is combinational; a write is visible the cycle after the edge that commits it.
// Backpressure: none; the sweep write wins over an update in the same cycle.
module pht_ram
   import branch_pred_pkg::*;
#(
   parameter int INDEX_BITS = 4
) (
   input  logic                  clk,
   input  logic [INDEX_BITS-1:0] rd_idx,
   output logic [1:0]            rd_cnt,
   input  logic                  sweep_we,
   input  logic [INDEX_BITS-1:0] sweep_idx,
   input  logic [1:0]            sweep_dat,
   input  logic                  upd_we,
   input  logic [INDEX_BITS-1:0] upd_idx,
   input  logic                  upd_taken
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   logic [1:0] mem_q [ENTRIES];
   logic [1:0] mem_d [ENTRIES];
   logic [1:0] upd_cnt;

   // Fetch read port, and the second read that feeds the update's read-modify-write
   assign rd_cnt  = mem_q[rd_idx];
   assign upd_cnt = mem_q[upd_idx];

   // Write mux: the sweep owns the table while initializing, otherwise the resolved branch
   always_comb begin
      mem_d = mem_q;
      if (sweep_we) begin
         mem_d[sweep_idx] = sweep_dat;
      end else if (upd_we) begin
         mem_d[upd_idx] = sat_next(upd_cnt, upd_taken);
      end
   end

   // Table storage carries no reset; the sweep establishes every entry before it is read
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch predictor controller: sequences PHT init sweep, fetch prediction, execute update and stats.
// Latency: prediction and mispredict are combinational; updates and counts land on the next edge.
// Backpressure: StallInitF holds fetch for 2^INDEX_BITS cycles after reset or a flush.
module branch_pred_ctrl
   import branch_pred_pkg::*;
#(
   parameter int         INDEX_BITS = 4,
   parameter int         PC_WIDTH   = 32,
   parameter logic [1:0] INIT_CNT   = 2'b01,
   parameter int         STAT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  FlushTable,
   input  logic [PC_WIDTH-1:0]   PCF,
   output logic                  PredictTakenF,
   output logic                  StallInitF,
   input  logic                  BranchE,
   input  logic [PC_WIDTH-1:0]   PCE,
   input  logic                  BranchTakenE,
   input  logic                  PredictedE,
   output logic                  MispredictE,
   output logic [STAT_WIDTH-1:0] BranchCount,
   output logic [STAT_WIDTH-1:0] MissCount
);

   localparam logic [INDEX_BITS-1:0] PTR_LAST = '1;
   localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

   ctrl_state_t           state_q, state_d;
   logic [INDEX_BITS-1:0] ptr_q, ptr_d;
   logic [STAT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
   logic [STAT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

   logic [INDEX_BITS-1:0] fetch_idx;
   logic [INDEX_BITS-1:0] exe_idx;
   logic [1:0]            fetch_cnt;
   logic                  run;
   logic                  sweep_we;
   logic                  upd_we;
   logic                  stat_clr;
   logic                  stat_cnt;
   logic                  unused_pc_bits;

   // Word-aligned index; low byte-offset bits and high bits alias freely
   assign fetch_idx = PCF[INDEX_BITS+1:2];
   assign exe_idx   = PCE[INDEX_BITS+1:2];
   assign unused_pc_bits = ^{PCF[PC_WIDTH-1:INDEX_BITS+2], PCF[1:0],
                             PCE[PC_WIDTH-1:INDEX_BITS+2], PCE[1:0]};

   // Control state register with synchronous reset into a fresh sweep
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: leave INIT after writing the last entry; a flush in RUN re-enters INIT
   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT:    if (ptr_q == PTR_LAST) state_d = RUN;
         RUN:     if (FlushTable) state_d = INIT;
         default: state_d = INIT;
      endcase
   end

   // Per-state controls; reset suppresses any table write on its edge
   always_comb begin
      run      = 1'b0;
      StallInitF = 1'b0;
      sweep_we = 1'b0;
      upd_we   = 1'b0;
      stat_clr = 1'b0;
      stat_cnt = 1'b0;
      case (state_q)
         INIT: begin
            StallInitF = 1'b1;
            sweep_we   = ~reset;
         end
         RUN: begin
            run      = 1'b1;
            upd_we   = BranchE & ~FlushTable & ~reset;
            stat_cnt = BranchE & ~FlushTable;
            stat_clr = FlushTable;
         end
         default: StallInitF = 1'b1;
      endcase
   end

   // Fetch prediction reads the pre-update value; no bypass from a same-cycle update
   assign PredictTakenF = run & fetch_cnt[1];
   // Mispredict is reported even on a cycle whose update a flush discards
   assign MispredictE   = run & BranchE & (BranchTakenE ^ PredictedE);

   // Sweep pointer advances only while writing; parked at zero in RUN so a flush starts at entry 0
   always_comb begin
      ptr_d = ptr_q;
      if (sweep_we) begin
         ptr_d = ptr_q + INDEX_BITS'(1);
      end else if (state_q == RUN) begin
         ptr_d = '0;
      end
   end

   // Saturating statistics: cleared by a flush, stepped by each accepted resolved branch
   always_comb begin
      branch_cnt_d = branch_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      if (stat_clr) begin
         branch_cnt_d = '0;
         miss_cnt_d   = '0;
      end else if (stat_cnt) begin
         if (branch_cnt_q != STAT_MAX) branch_cnt_d = branch_cnt_q + STAT_WIDTH'(1);
         if (MispredictE && (miss_cnt_q != STAT_MAX)) miss_cnt_d = miss_cnt_q + STAT_WIDTH'(1);
      end
   end

   // Pointer and statistics registers
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q        <= '0;
         branch_cnt_q <= '0;
         miss_cnt_q   <= '0;
      end else begin
         ptr_q        <= ptr_d;
         branch_cnt_q <= branch_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   assign BranchCount = branch_cnt_q;
   assign MissCount   = miss_cnt_q;

   pht_ram #(
      .INDEX_BITS (INDEX_BITS)
   ) u_pht (
      .clk       (clk),
      .rd_idx    (fetch_idx),
      .rd_cnt    (fetch_cnt),
      .sweep_we  (sweep_we),
      .sweep_idx (ptr_q),
      .sweep_dat (INIT_CNT),
      .upd_we    (upd_we),
      .upd_idx   (exe_idx),
      .upd_taken (BranchTakenE)
   );

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Self-checking bench for branch_pred_ctrl: directed scenarios plus randomized traffic vs a behavioural model.
// Latency: model expects combinational prediction/mispredict and next-edge table/counter effects.
// Backpressure: model treats a nonzero remaining-sweep count as fetch stall.
module tb_branch_pred_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        FlushTable;
   logic [31:0] PCF;
   logic        PredictTakenF;
   logic        StallInitF;
   logic        BranchE;
   logic [31:0] PCE;
   logic        BranchTakenE;
   logic        PredictedE;
   logic        MispredictE;
   logic [15:0] BranchCount;
   logic [15:0] MissCount;

   int tests = 0;
   int fails = 0;
   bit check_en = 1'b0;

   // Behavioural model: table of counter values 0..3, cycles of sweep left, plain integer stats
   int m_tbl [16];
   int m_sweep_left = 16;
   int m_bc = 0;
   int m_mc = 0;

   always #5 clk = ~clk;

   branch_pred_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .FlushTable    (FlushTable),
      .PCF           (PCF),
      .PredictTakenF (PredictTakenF),
      .StallInitF    (StallInitF),
      .BranchE       (BranchE),
      .PCE           (PCE),
      .BranchTakenE  (BranchTakenE),
      .PredictedE    (PredictedE),
      .MispredictE   (MispredictE),
      .BranchCount   (BranchCount),
      .MissCount     (MissCount)
   );

   function automatic int idx_of(input logic [31:0] pc);
      logic [3:0] i;
      i = pc[5:2];
      return int'(i);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge, where inputs are driven
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Count cycles with the stall high, starting now; bounded so a stuck stall still ends
   task automatic wait_sweep(input string name);
      int n;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         #2;
         if (!StallInitF) break;
         n++;
         @(posedge clk);
         #1;
      end
      chk(name, n, 16);
   endtask

   // Model state advance on each edge from the inputs that edge samples
   always @(posedge clk) begin
      int i;
      if (reset) begin
         m_sweep_left = 16;
         m_bc = 0;
         m_mc = 0;
      end else if (m_sweep_left > 0) begin
         m_tbl[16 - m_sweep_left] = 1;
         m_sweep_left--;
      end else if (FlushTable) begin
         m_sweep_left = 16;
         m_bc = 0;
         m_mc = 0;
      end else if (BranchE) begin
         i = idx_of(PCE);
         if (BranchTakenE) m_tbl[i] = (m_tbl[i] < 3) ? m_tbl[i] + 1 : 3;
         else              m_tbl[i] = (m_tbl[i] > 0) ? m_tbl[i] - 1 : 0;
         if (m_bc < 65535) m_bc++;
         if ((BranchTakenE != PredictedE) && (m_mc < 65535)) m_mc++;
      end
   end

   // Every-cycle comparison of all outputs against the model, mid-cycle
   always @(negedge clk) begin
      bit busy;
      if (check_en) begin
         busy = (m_sweep_left > 0);
         chk("model_stall", StallInitF, busy);
         chk("model_pred", PredictTakenF, !busy && (m_tbl[idx_of(PCF)] >= 2));
         chk("model_mispred", MispredictE, !busy && BranchE && (BranchTakenE != PredictedE));
         chk("model_bcount", BranchCount, m_bc);
         chk("model_mcount", MissCount, m_mc);
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; FlushTable = 1'b0; PCF = '0; PCE = '0;
      BranchE = 1'b0; BranchTakenE = 1'b0; PredictedE = 1'b0;

      // 1: reset, then exactly 16 stall cycles and every entry weakly not-taken
      cyc();
      check_en = 1'b1;
      reset = 1'b0;
      #2;
      chk("s1_reset_bcount", BranchCount, 0);
      chk("s1_reset_mcount", MissCount, 0);
      chk("s1_reset_pred", PredictTakenF, 0);
      chk("s1_reset_mispred", MispredictE, 0);
      #0;
      cyc();
      // first sample was taken after one edge; re-run from a fresh reset for an exact count
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      wait_sweep("s1_stall_len");
      cyc();
      for (int k = 0; k < 16; k++) begin
         PCF = 32'(k * 4);
         #2;
         chk("s1_init_pred", PredictTakenF, 0);
         cyc();
      end

      // 2: three taken updates on entry 2; prediction rises after the first
      BranchE = 1'b1; PCE = 32'h08; BranchTakenE = 1'b1; PredictedE = 1'b1; PCF = 32'h08;
      #2;
      chk("s2_pred_before", PredictTakenF, 0);
      cyc();
      #2;
      chk("s2_pred_after1", PredictTakenF, 1);
      cyc();
      cyc();
      BranchE = 1'b0; PCF = 32'h18;
      #2;
      chk("s2_untouched", PredictTakenF, 0);
      PCF = 32'h08;
      #1;
      chk("s2_entry2_taken", PredictTakenF, 1);
      chk("s2_bcount", BranchCount, 3);
      chk("s2_mcount", MissCount, 0);

      // 4: same-cycle hit sees the old value, new value next cycle
      cyc();
      PCF = 32'h0C; PCE = 32'h0C; BranchE = 1'b1; BranchTakenE = 1'b1; PredictedE = 1'b0;
      #2;
      chk("s4_same_cycle", PredictTakenF, 0);
      chk("s4_mispred", MispredictE, 1);
      cyc();
      BranchE = 1'b0;
      #2;
      chk("s4_next_cycle", PredictTakenF, 1);

      // 5: flush with a branch in the same cycle
      cyc();
      PCE = 32'h08; PCF = 32'h08; BranchE = 1'b1; BranchTakenE = 1'b0; PredictedE = 1'b1;
      FlushTable = 1'b1;
      #2;
      chk("s5_mispred_driven", MispredictE, 1);
      chk("s5_pred_strong", PredictTakenF, 1);
      cyc();
      BranchE = 1'b0; FlushTable = 1'b0;
      wait_sweep("s5_stall_len");
      cyc();
      #2;
      chk("s5_entry2_reinit", PredictTakenF, 0);
      chk("s5_bcount_clr", BranchCount, 0);
      chk("s5_mcount_clr", MissCount, 0);

      // 3: one mispredicted branch steps both counters
      cyc();
      BranchE = 1'b1; PCE = 32'h20; BranchTakenE = 1'b0; PredictedE = 1'b1;
      #2;
      chk("s3_mispred", MispredictE, 1);
      cyc();
      BranchE = 1'b0;
      #2;
      chk("s3_mcount", MissCount, 1);
      chk("s3_bcount", BranchCount, 1);

      // Randomized traffic with occasional flush and reset
      for (int i = 0; i < 3000; i++) begin
         cyc();
         reset        = ($urandom_range(0, 255) == 0);
         FlushTable   = ($urandom_range(0, 63) == 0);
         BranchE      = $urandom_range(0, 1) == 1;
         PCE          = $urandom;
         PCF          = $urandom;
         BranchTakenE = $urandom_range(0, 1) == 1;
         PredictedE   = $urandom_range(0, 1) == 1;
      end

      // 6: reset at sweep pointer 7 restarts the full sweep
      cyc();
      reset = 1'b1; FlushTable = 1'b0; BranchE = 1'b0;
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 7; i++) cyc();
      #2;
      chk("s6_mid_sweep_stall", StallInitF, 1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      wait_sweep("s6_restart_len");

      // 6: branch counter saturates at all-ones
      cyc();
      BranchE = 1'b1;
      for (int i = 0; i < 65540; i++) begin
         PCE          = $urandom;
         PCF          = $urandom;
         BranchTakenE = $urandom_range(0, 1) == 1;
         PredictedE   = $urandom_range(0, 1) == 1;
         cyc();
      end
      BranchE = 1'b0;
      #2;
      chk("s6_bcount_sat", BranchCount, 32'h0000_FFFF);

      cyc();
      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
